iq_avg_accum: RTL and testbench
===============================

# iq_avg_accum

Per-channel I/Q time-averager feeding the averaged-IQ snapshot BRAM (port A) in the wavelength-readout pipeline. Consumes the channelized I/Q stream (1024 channels, one sample per valid cycle, sync on channel 0). It accumulates 2^k frames per channel in an internal accumulator RAM. On the final frame it writes the packed averages {I,Q} to the snapshot BRAM at address = channel, then raises `done` for software readout.

## Interface
Parameters:
- `CH_LOG2`, 10, log2 channel count; it is also the BRAM address width.
- `DW`, 16, signed I and Q sample width.
- `MAX_LOG2_FRAMES`, 8, largest supported k. The accumulator width is ACC_W = DW+MAX_LOG2_FRAMES.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  fabric clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  software start level; internally rising-edge detected
- `log2_frames`  in  4  k, sampled on the accepted start edge
- `in_valid`  in  1  input sample qualifier
- `in_sync`  in  1  with in_valid: this sample is channel 0
- `in_i`  in  DW  signed I sample
- `in_q`  in  DW  signed Q sample
- `bram_we`  out  1  snapshot BRAM write enable
- `bram_en_a`  out  1  snapshot BRAM enable; equals bram_we
- `bram_addr`  out  CH_LOG2  channel index
- `bram_wr_data`  out  32  {I_avg[15:0], Q_avg[15:0]}
- `busy`  out  1  capture in progress
- `done`  out  1  averages valid in BRAM; sticky until the next accepted start
- `sync_err`  out  1  sticky; sync arrived when the channel counter was not 2^CH_LOG2-1

## Operation
- States are IDLE, WAIT_SYNC, ACCUM and DONE.
- IDLE / DONE on a start rising edge:
  - latch k = min(log2_frames, MAX_LOG2_FRAMES);
  - clear done and sync_err;
  - go to WAIT_SYNC.
- A start edge while in WAIT_SYNC or ACCUM is ignored.
- WAIT_SYNC: the first in_valid&in_sync sample sets ch=0 and frame=0, moves to ACCUM, and that sample is processed.
- ACCUM, per valid sample:
  - ch increments and wraps at 2^CH_LOG2-1;
  - frame increments when a sample with ch=2^CH_LOG2-1 is processed.
- Accumulate: on frame 0, sum = sample, and the RAM contents are ignored, so no clear pass is needed. Otherwise, sum = RAM[ch] + sample, sign-extended to ACC_W.
- Last frame (frame = 2^k-1):
  - avg = sum >>> k (arithmetic shift);
  - write avg to the BRAM at ch;
  - the RAM writeback is don't-care.
- k=0: every sample is written straight through, one frame only.
- After the write for ch=2^CH_LOG2-1 of the last frame: go to DONE, set done=1, clear busy.
- Sync when ch ≠ 2^CH_LOG2-1 in ACCUM (misaligned stream):
  - set sync_err;
  - treat the sample as channel 0 of frame 0, restarting the average.
- A sync on the expected channel-0 position is normal and is ignored.
- Samples arriving in IDLE and DONE are ignored, and no writes occur in those states.
- in_valid gaps stall the pipeline stage-wise; no sample is lost or duplicated.

## Timing
- Reset values: bram_we=0, bram_en_a=0, bram_addr=0, bram_wr_data=0, busy=0, done=0, sync_err=0, state=IDLE.
- `rst` mid-capture aborts to IDLE on the next edge, with no further BRAM writes.
- Pipeline:
  - cycle 0: accumulator RAM read address = ch;
  - cycle 1: read data available, add;
  - cycle 2: RAM writeback or BRAM write registered.
- Sample-to-bram_we latency is therefore 2 cycles.
- A read of channel c and a writeback of c are separated by a full frame (≥1024 valid samples), so the design has no read-after-write hazard and needs no forwarding.
- busy rises the cycle after the accepted start edge.
- done rises in the same cycle as the final bram_we.

## Configuration
- `IQ_AVG_ROUND_EN`
  - Defined: before the shift, add 2^(k-1) when k>0 (round half up). Saturate the result to [−2^(DW-1), 2^(DW-1)−1].
  - Undefined: plain truncating arithmetic shift. No saturation logic is needed because the result always fits in DW.

## Structure
- Package `iq_avg_pkg` holds:
  - DW, ACC_W, the state enum;
  - the pack function {I,Q}→32 bits;
  - the shift/round function.
- Sub-module `iq_avg_acc_ram`: simple dual-port, 1-cycle-read inferred RAM, 2^CH_LOG2 × 2·ACC_W.

## Test plan
- k=2, constant I=100 and Q=−100 on all channels, 4 frames:
  - exactly 1024 writes, addr 0..1023;
  - data 0x0064FF9C;
  - done=1 and busy=0 after the last write.
- k=1, channel 5 with I=3 then I=4:
  - truncated build: I_avg=3;
  - `IQ_AVG_ROUND_EN` build: I_avg=4.
  - Check I=−3 then −4 as well: truncated −4, rounded −3.
- Sync injected at ch=500 of frame 1:
  - sync_err=1;
  - the average restarts, with exactly 1024 writes after 2^k clean frames from that sync.
- Random in_valid gaps at 30% idle, k=3, random samples:
  - BRAM contents match the reference-model floor averages;
  - no missing or extra writes.
- Start asserted again mid-capture:
  - ignored, with no change to k.
- `rst` pulsed mid-frame 2:
  - all outputs return to their reset values and no writes follow.
  - A new start after reset completes a full capture correctly.
- Rounding saturation, k=1, I=0x7FFF twice, rounded build:
  - I_avg=0x7FFF with no wrap.

Source files
------------

// File: rtl/iq_avg_pkg.sv
// Shared types and arithmetic helpers for the per-channel I/Q averager.
// IQ_AVG_ROUND_EN selects round-half-up with saturation instead of truncation.
package iq_avg_pkg;

    localparam int DW              = 16;
    localparam int MAX_LOG2_FRAMES = 8;
    localparam int ACC_W           = DW + MAX_LOG2_FRAMES;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        ACCUM,
        DONE
    } state_t;

`ifdef IQ_AVG_ROUND_EN
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(DW-1) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;
`endif

    function automatic logic [31:0] pack_iq(
        input logic [DW-1:0] i,
        input logic [DW-1:0] q
    );
        return {i[15:0], q[15:0]};
    endfunction

    function automatic logic [DW-1:0] avg_shift(
        input logic [ACC_W-1:0] sum,
        input logic [3:0]       k
    );
        logic signed [ACC_W:0] t;
        t = $signed({sum[ACC_W-1], sum});
`ifdef IQ_AVG_ROUND_EN
        if (k != 4'd0) begin
            t = t + ((ACC_W+1)'(1) << (k - 4'd1));
        end
        t = t >>> k;
        if (t > SAT_HI) begin
            t = SAT_HI;
        end else if (t < SAT_LO) begin
            t = SAT_LO;
        end
`else
        t = t >>> k;
`endif
        return t[DW-1:0];
    endfunction

endpackage

// File: rtl/iq_avg_acc_ram.sv
// Simple dual-port accumulator RAM with a registered read port.
// Holds the running {I,Q} sums, one word per channel.
module iq_avg_acc_ram #(
    parameter int AW = 10,
    parameter int W  = 48
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iq_avg_accum.sv
// Per-channel I/Q time-averager writing 2^k-frame averages to the snapshot BRAM.
// Build option IQ_AVG_ROUND_EN enables rounding and saturation of the averages.
module iq_avg_accum #(
    parameter int CH_LOG2         = 10,
    parameter int DW              = 16,
    parameter int MAX_LOG2_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           log2_frames,
    input  logic                 in_valid,
    input  logic                 in_sync,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    output logic                 bram_we,
    output logic                 bram_en_a,
    output logic [CH_LOG2-1:0]   bram_addr,
    output logic [31:0]          bram_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sync_err
);

    import iq_avg_pkg::*;

    localparam int FR_W  = MAX_LOG2_FRAMES + 1;
    localparam int RAM_W = 2 * ACC_W;

    state_t               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic [CH_LOG2-1:0]   nch_q, nch_d, cur_ch;
    logic [FR_W-1:0]      nfr_q, nfr_d, cur_fr, nframes;
    logic                 done_q, done_d;
    logic                 serr_q, serr_d;
    logic                 start_q, start_edge, acc;

    logic                 s1_v_q, s1_first_q, s1_last_q;
    logic [CH_LOG2-1:0]   s1_ch_q;
    logic signed [DW-1:0] s1_i_q, s1_q_q;
    logic                 s1_end;

    logic                 we_q;
    logic [CH_LOG2-1:0]   addr_q;
    logic [31:0]          data_q;

    logic [RAM_W-1:0]     rd_data;
    logic [ACC_W-1:0]     ext_i, ext_q, sum_i, sum_q;

    assign nframes    = FR_W'(1) << k_q;
    assign start_edge = start & ~start_q;
    assign s1_end     = s1_v_q & s1_last_q & (&s1_ch_q);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        nch_d   = nch_q;
        nfr_d   = nfr_q;
        done_d  = done_q;
        serr_d  = serr_q;
        acc     = 1'b0;
        cur_ch  = nch_q;
        cur_fr  = nfr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    k_d = (log2_frames > 4'(MAX_LOG2_FRAMES)) ?
                          4'(MAX_LOG2_FRAMES) : log2_frames;
                    done_d  = 1'b0;
                    serr_d  = 1'b0;
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (in_valid && in_sync) begin
                    acc     = 1'b1;
                    cur_ch  = '0;
                    cur_fr  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Once the final sample is taken, drain until its write lands.
                if (in_valid && (nfr_q != nframes)) begin
                    acc = 1'b1;
                    if (in_sync && (nch_q != '0)) begin
                        serr_d = 1'b1;
                        cur_ch = '0;
                        cur_fr = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc) begin
            nch_d = cur_ch + 1'b1;
            nfr_d = cur_fr + FR_W'(&cur_ch);
        end
        if (s1_end) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        ext_i = {{(ACC_W-DW){s1_i_q[DW-1]}}, s1_i_q};
        ext_q = {{(ACC_W-DW){s1_q_q[DW-1]}}, s1_q_q};
        sum_i = s1_first_q ? ext_i : rd_data[RAM_W-1:ACC_W] + ext_i;
        sum_q = s1_first_q ? ext_q : rd_data[ACC_W-1:0] + ext_q;
    end

    iq_avg_acc_ram #(
        .AW (CH_LOG2),
        .W  (RAM_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (s1_v_q & ~s1_last_q),
        .waddr_i (s1_ch_q),
        .wdata_i ({sum_i, sum_q}),
        .raddr_i (cur_ch),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            nch_q      <= '0;
            nfr_q      <= '0;
            done_q     <= 1'b0;
            serr_q     <= 1'b0;
            start_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_ch_q    <= '0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            nch_q   <= nch_d;
            nfr_q   <= nfr_d;
            done_q  <= done_d;
            serr_q  <= serr_d;
            start_q <= start;
            s1_v_q  <= acc;
            if (acc) begin
                s1_ch_q    <= cur_ch;
                s1_i_q     <= in_i;
                s1_q_q     <= in_q;
                s1_first_q <= (cur_fr == '0);
                s1_last_q  <= (cur_fr == nframes - FR_W'(1));
            end
            we_q <= s1_v_q & s1_last_q;
            if (s1_v_q && s1_last_q) begin
                addr_q <= s1_ch_q;
                data_q <= pack_iq(avg_shift(sum_i, k_q),
                                  avg_shift(sum_q, k_q));
            end
        end
    end

    assign bram_we      = we_q;
    assign bram_en_a    = we_q;
    assign bram_addr    = addr_q;
    assign bram_wr_data = data_q;
    assign busy         = (state_q == WAIT_SYNC) || (state_q == ACCUM);
    assign done         = done_q;
    assign sync_err     = serr_q;

endmodule

// File: tb/tb_iq_avg_accum.sv
// Self-checking bench for iq_avg_accum: arithmetic reference averages per capture.
// Honours IQ_AVG_ROUND_EN for the expected rounding behaviour.
module tb_iq_avg_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [3:0]         log2_frames = '0;
    logic               in_valid = 1'b0;
    logic               in_sync = 1'b0;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic               bram_we, bram_en_a, busy, done, sync_err;
    logic [9:0]         bram_addr;
    logic [31:0]        bram_wr_data;

    always #5 clk = ~clk;

    iq_avg_accum dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .log2_frames  (log2_frames),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .in_i         (in_i),
        .in_q         (in_q),
        .bram_we      (bram_we),
        .bram_en_a    (bram_en_a),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .busy         (busy),
        .done         (done),
        .sync_err     (sync_err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    exp_t        expq[$];
    logic [31:0] bram_mem [1024];
    int          fi [8][1024];
    int          fq [8][1024];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference average: exact floor (or round-half-up) division of the frame sum.
    function automatic int ref_avg(input longint sum, input int k);
        longint n;
        longint r;
        n = longint'(1) << k;
`ifdef IQ_AVG_ROUND_EN
        if (k > 0) sum = sum + n / 2;
`endif
        r = sum / n;
        if ((sum % n) != 0 && sum < 0) r = r - 1;
`ifdef IQ_AVG_ROUND_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return int'(r);
    endfunction

    function automatic logic [31:0] pack(input int a, input int b);
        return {a[15:0], b[15:0]};
    endfunction

    task automatic build_expect(input int k);
        longint si, sq;
        exp_t   e;
        for (int c = 0; c < 1024; c++) begin
            si = 0;
            sq = 0;
            for (int f = 0; f < (1 << k); f++) begin
                si += fi[f][c];
                sq += fq[f][c];
            end
            e.addr = c;
            e.data = pack(ref_avg(si, k), ref_avg(sq, k));
            e.last = (c == 1023);
            expq.push_back(e);
        end
        wr_cnt = 0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        checks++;
        if (bram_en_a !== bram_we) begin
            errors++;
            $display("FAIL en_mirror: en=%b we=%b", bram_en_a, bram_we);
        end
        if (bram_we === 1'b1) begin
            wr_cnt++;
            bram_mem[bram_addr] = bram_wr_data;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h",
                         bram_addr, bram_wr_data);
            end else begin
                e = expq.pop_front();
                if (bram_addr !== 10'(e.addr) || bram_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got %0d/%h want %0d/%h",
                             bram_addr, bram_wr_data, e.addr, e.data);
                end
                if (e.last) begin
                    checks++;
                    if (done !== 1'b1 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL last_write_flags: done=%b busy=%b want 1/0",
                                 done, busy);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input int i, input int q);
        in_valid = v;
        in_sync  = s;
        in_i     = 16'(i);
        in_q     = 16'(q);
        step();
    endtask

    task automatic send_range(input int f, input int lo, input int hi,
                              input int gap);
        for (int c = lo; c <= hi; c++) begin
            while (int'($urandom_range(99)) < gap) drive(0, 0, 0, 0);
            drive(1, c == 0, fi[f][c], fq[f][c]);
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic do_start(input int k);
        start       = 1'b1;
        log2_frames = 4'(k);
        step();
        chk("busy_rise", {63'd0, busy}, 64'd1);
        start = 1'b0;
        step();
    endtask

    task automatic wait_done(input string nm, input bit serr);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        @(negedge clk);
        #1;
        chk({nm, "_done"}, {63'd0, done}, 64'd1);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_pending"}, 64'(expq.size()), 64'd0);
        chk({nm, "_writes"}, 64'(wr_cnt), 64'd1024);
        chk({nm, "_sync_err"}, {63'd0, sync_err}, {63'd0, serr});
        expq.delete();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_we"}, {63'd0, bram_we}, 64'd0);
        chk({nm, "_en"}, {63'd0, bram_en_a}, 64'd0);
        chk({nm, "_addr"}, 64'(bram_addr), 64'd0);
        chk({nm, "_data"}, 64'(bram_wr_data), 64'd0);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_done"}, {63'd0, done}, 64'd0);
        chk({nm, "_serr"}, {63'd0, sync_err}, 64'd0);
    endtask

    task automatic fill_random(input int nf);
        logic [15:0] r;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < 1024; c++) begin
                r = 16'($urandom);
                fi[f][c] = int'($signed(r));
                r = 16'($urandom);
                fq[f][c] = int'($signed(r));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e5, e6;
        repeat (3) step();
        chk_reset("por");
        rst = 1'b0;
        step();
        chk_reset("idle");

        // Constant I=100, Q=-100, k=2
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 1024; c++) begin
                fi[f][c] = 100;
                fq[f][c] = -100;
            end
        end
        build_expect(2);
        do_start(2);
        for (int f = 0; f < 4; f++) send_range(f, 0, 1023, 0);
        wait_done("const", 1'b0);
        chk("const_ch0", 64'(bram_mem[0]), 64'h0064FF9C);
        chk("const_ch1023", 64'(bram_mem[1023]), 64'h0064FF9C);

        // k=1 rounding pins on channels 5..7
        for (int c = 0; c < 1024; c++) begin
            fi[0][c] = c - 512;
            fi[1][c] = 3 * c - 1500;
            fq[0][c] = 7 - c;
            fq[1][c] = c;
        end
        fi[0][5] = 3;      fi[1][5] = 4;
        fi[0][6] = -3;     fi[1][6] = -4;
        fi[0][7] = 32767;  fi[1][7] = 32767;
        build_expect(1);
        do_start(1);
        send_range(0, 0, 1023, 0);
        send_range(1, 0, 1023, 0);
        wait_done("k1", 1'b0);
`ifdef IQ_AVG_ROUND_EN
        e5 = 16'd4;
        e6 = 16'hFFFD;
`else
        e5 = 16'd3;
        e6 = 16'hFFFC;
`endif
        chk("pin_ch5_I", 64'(bram_mem[5][31:16]), 64'(e5));
        chk("pin_ch6_I", 64'(bram_mem[6][31:16]), 64'(e6));
        chk("pin_ch7_I", 64'(bram_mem[7][31:16]), 64'h7FFF);

        // Misaligned sync at ch 500 of frame 1, k=2
        fill_random(2);
        do_start(2);
        send_range(0, 0, 1023, 0);
        send_range(1, 0, 499, 0);
        fill_random(4);
        build_expect(2);
        for (int f = 0; f < 4; f++) send_range(f, 0, 1023, 0);
        wait_done("sync", 1'b1);

        // Random samples, 30% idle gaps, k=3
        fill_random(8);
        build_expect(3);
        do_start(3);
        chk("serr_cleared", {63'd0, sync_err}, 64'd0);
        for (int f = 0; f < 8; f++) send_range(f, 0, 1023, 30);
        wait_done("rand", 1'b0);

        // Start re-asserted mid-capture with a different k
        fill_random(2);
        build_expect(1);
        do_start(1);
        send_range(0, 0, 299, 0);
        start       = 1'b1;
        log2_frames = 4'd3;
        send_range(0, 300, 1023, 0);
        start = 1'b0;
        send_range(1, 0, 1023, 0);
        wait_done("midstart", 1'b0);

        // Reset pulsed during frame 2, then a fresh k=0 capture
        fill_random(3);
        wr_cnt = 0;
        do_start(2);
        send_range(0, 0, 1023, 0);
        send_range(1, 0, 1023, 0);
        send_range(2, 0, 299, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("midrst");
        send_range(2, 0, 299, 0);
        repeat (5) step();
        chk("midrst_nowrites", 64'(wr_cnt), 64'd0);
        fill_random(1);
        build_expect(0);
        do_start(0);
        send_range(0, 0, 1023, 0);
        wait_done("k0", 1'b0);
        chk("k0_ch3", 64'(bram_mem[3]), 64'(pack(fi[0][3], fq[0][3])));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
